// File: rtl/fios_res_collector.sv
// Gathers s WORD_W-bit FIOS result limbs (LSB first) into one s*WORD_W result; `FIOS_RES_FINAL_SUB_EN adds serial final subtraction of p.
// Latency: res_valid_o rises the cycle after the edge capturing the last limb; res_o is valid in that same cycle.
// Backpressure: result held until res_ready_i; a limb arriving while full is dropped and sets sticky overflow_o.
module fios_res_collector #(
   parameter int s      = 8,
   parameter int WORD_W = 17
) (
   input  logic                      clock_i,
   input  logic                      reset_n_i,
   input  logic                      word_valid_i,
   input  logic [WORD_W-1:0]         word_i,
   input  logic [s*WORD_W-1:0]       p_i,
   output logic [s*WORD_W-1:0]       res_o,
   output logic                      res_valid_o,
   input  logic                      res_ready_i,
   output logic                      busy_o,
   output logic                      overflow_o,
   output logic [$clog2(s+1)-1:0]    word_cnt_o
);

   localparam int CNT_W = $clog2(s+1);
   localparam int IDX_W = (s > 1) ? $clog2(s) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(s-1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   logic [1:0]        state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic              overflow_q, overflow_set;
   logic [WORD_W-1:0] raw_q [s];

   logic              accept;
   logic              first_limb;
   logic [IDX_W-1:0]  wr_idx;

   // A limb accepted outside COLLECT is always limb 0 of a new result.
   assign first_limb = (state_q != ST_COLLECT);
   assign wr_idx     = first_limb ? '0 : cnt_q[IDX_W-1:0];
   assign accept     = word_valid_i &&
                       ((state_q == ST_IDLE) || (state_q == ST_COLLECT) ||
                        ((state_q == ST_FULL) && res_ready_i));

   always_comb begin
      state_nxt    = state_q;
      cnt_nxt      = cnt_q;
      overflow_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (word_valid_i) begin
               cnt_nxt   = CNT_W'(1);
               state_nxt = (s == 1) ? ST_FULL : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (word_valid_i) begin
               cnt_nxt = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_nxt = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            if (res_ready_i) begin
               if (word_valid_i) begin
                  cnt_nxt   = CNT_W'(1);
                  state_nxt = (s == 1) ? ST_FULL : ST_COLLECT;
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = ST_IDLE;
               end
            end else if (word_valid_i) begin
               overflow_set = 1'b1;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         for (int k = 0; k < s; k++) begin
            raw_q[k] <= '0;
         end
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         if (overflow_set) begin
            overflow_q <= 1'b1;
         end
         if (accept) begin
            raw_q[wr_idx] <= word_i;
         end
      end
   end

`ifdef FIOS_RES_FINAL_SUB_EN
   logic [WORD_W-1:0] diff_q [s];
   logic [WORD_W-1:0] p_limb [s];
   logic              borrow_q;
   logic              sel_q;
   logic              borrow_in;
   logic              last_limb;
   logic [WORD_W:0]   diff_full;

   for (genvar k = 0; k < s; k++) begin : g_p_limb
      assign p_limb[k] = p_i[k*WORD_W +: WORD_W];
   end

   assign borrow_in = first_limb ? 1'b0 : borrow_q;
   assign last_limb = (wr_idx == IDX_W'(s-1));
   assign diff_full = {1'b0, word_i} - {1'b0, p_limb[wr_idx]} - {{WORD_W{1'b0}}, borrow_in};

   // A final borrow means RES < p, so the raw limbs are already reduced.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         borrow_q <= 1'b0;
         sel_q    <= 1'b0;
         for (int k = 0; k < s; k++) begin
            diff_q[k] <= '0;
         end
      end else if (accept) begin
         diff_q[wr_idx] <= diff_full[WORD_W-1:0];
         borrow_q       <= diff_full[WORD_W];
         if (last_limb) begin
            sel_q <= diff_full[WORD_W];
         end
      end
   end

   for (genvar k = 0; k < s; k++) begin : g_res
      assign res_o[k*WORD_W +: WORD_W] = sel_q ? raw_q[k] : diff_q[k];
   end
`else
   logic unused_p;
   assign unused_p = ^p_i;

   for (genvar k = 0; k < s; k++) begin : g_res
      assign res_o[k*WORD_W +: WORD_W] = raw_q[k];
   end
`endif

   assign res_valid_o = (state_q == ST_FULL);
   assign busy_o      = (state_q == ST_COLLECT);
   assign overflow_o  = overflow_q;
   assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Bench for fios_res_collector: an s=2 and an s=8 instance checked against a value-level model plus literal expectations.
module tb_fios_res_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n [2];
   logic          vld   [2];
   logic          rdy   [2];
   logic [16:0]   w     [2];
   logic [135:0]  p_all [2];

   logic [33:0]   res0;
   logic [135:0]  res1;
   logic          rv   [2];
   logic          busy [2];
   logic          ovf  [2];
   logic [1:0]    cnt0;
   logic [3:0]    cnt1;

   fios_res_collector #(.s(2), .WORD_W(17)) u_dut0 (
      .clock_i(clk), .reset_n_i(rst_n[0]), .word_valid_i(vld[0]), .word_i(w[0]),
      .p_i(p_all[0][33:0]), .res_o(res0), .res_valid_o(rv[0]), .res_ready_i(rdy[0]),
      .busy_o(busy[0]), .overflow_o(ovf[0]), .word_cnt_o(cnt0)
   );

   fios_res_collector #(.s(8), .WORD_W(17)) u_dut1 (
      .clock_i(clk), .reset_n_i(rst_n[1]), .word_valid_i(vld[1]), .word_i(w[1]),
      .p_i(p_all[1]), .res_o(res1), .res_valid_o(rv[1]), .res_ready_i(rdy[1]),
      .busy_o(busy[1]), .overflow_o(ovf[1]), .word_cnt_o(cnt1)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value-level model: limbs accumulate into an integer; completion yields RES or RES-p.
   int           m_cnt  [2];
   bit           m_pend [2];
   bit           m_ovf  [2];
   bit           m_zero [2];
   logic [135:0] m_acc  [2];
   logic [135:0] m_res  [2];

   function automatic logic [135:0] reduce(input logic [135:0] v, input logic [135:0] p);
`ifdef FIOS_RES_FINAL_SUB_EN
      return (v >= p) ? v - p : v;
`else
      return v + (p & 136'd0);
`endif
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0; m_pend[d] = 0; m_ovf[d] = 0; m_zero[d] = 1;
         m_acc[d] = '0; m_res[d] = '0;
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int  ns;
         bit  take;
         ns = (d == 0) ? 2 : 8;
         if (!rst_n[d]) begin
            m_cnt[d] = 0; m_pend[d] = 0; m_ovf[d] = 0; m_zero[d] = 1; m_acc[d] = '0;
         end else begin
            take = vld[d] && (!m_pend[d] || rdy[d]);
            if (m_pend[d] && rdy[d]) begin
               m_pend[d] = 0; m_cnt[d] = 0; m_acc[d] = '0;
            end else if (m_pend[d] && vld[d]) begin
               m_ovf[d] = 1;
            end
            if (take) begin
               m_acc[d][m_cnt[d]*17 +: 17] = w[d];
               m_cnt[d]++;
               m_zero[d] = 0;
               if (m_cnt[d] == ns) begin
                  m_pend[d] = 1;
                  m_res[d]  = reduce(m_acc[d], p_all[d]);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("m0_valid", {135'd0, rv[0]},   {135'd0, m_pend[0]});
      chk("m0_busy",  {135'd0, busy[0]}, {135'd0, !m_pend[0] && m_cnt[0] > 0});
      chk("m0_ovf",   {135'd0, ovf[0]},  {135'd0, m_ovf[0]});
      chk("m0_cnt",   {134'd0, cnt0},    136'(m_cnt[0]));
      if (m_pend[0] || m_zero[0]) chk("m0_res", {102'd0, res0}, m_zero[0] ? 136'd0 : m_res[0]);
      chk("m1_valid", {135'd0, rv[1]},   {135'd0, m_pend[1]});
      chk("m1_busy",  {135'd0, busy[1]}, {135'd0, !m_pend[1] && m_cnt[1] > 0});
      chk("m1_ovf",   {135'd0, ovf[1]},  {135'd0, m_ovf[1]});
      chk("m1_cnt",   {132'd0, cnt1},    136'(m_cnt[1]));
      if (m_pend[1] || m_zero[1]) chk("m1_res", res1, m_zero[1] ? 136'd0 : m_res[1]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [135:0] exp8;
   int           pulses [$];

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; vld[d] = 1'b0; rdy[d] = 1'b0; w[d] = '0;
      end
      p_all[0] = {102'd0, {34{1'b1}}};
      p_all[1] = {136{1'b1}};
      tick(); tick();
      chk("rst_valid0", {135'd0, rv[0]}, 136'd0);
      chk("rst_res0",   {102'd0, res0},  136'd0);
      chk("rst_cnt0",   {134'd0, cnt0},  136'd0);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      // Test 1: two consecutive limbs, ready high
      rdy[0] = 1'b1;
      vld[0] = 1'b1; w[0] = 17'h00005; tick();
      w[0] = 17'h00003; tick();
      vld[0] = 1'b0;
      chk("t1_valid", {135'd0, rv[0]}, 136'd1);
      chk("t1_res",   {102'd0, res0},  136'h60005);
      tick();
      chk("t1_idle_valid", {135'd0, rv[0]}, 136'd0);
      chk("t1_idle_cnt",   {134'd0, cnt0},  136'd0);

      // Test 2: gap of three idle cycles between limbs
      rdy[0] = 1'b0;
      vld[0] = 1'b1; w[0] = 17'h1FFFF; tick();
      vld[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_gap_busy", {135'd0, busy[0]}, 136'd1);
         chk("t2_gap_cnt",  {134'd0, cnt0},    136'd1);
      end
      vld[0] = 1'b1; w[0] = 17'h00001; tick();
      vld[0] = 1'b0;
      chk("t2_res", {102'd0, res0}, 136'h3FFFF);

      // Test 3: stall, overflow, then handshake with a new limb 0
      for (int i = 0; i < 4; i++) tick();
      chk("t3_hold_valid", {135'd0, rv[0]}, 136'd1);
      vld[0] = 1'b1; w[0] = 17'h00777; tick();
      vld[0] = 1'b0;
      chk("t3_ovf", {135'd0, ovf[0]}, 136'd1);
      chk("t3_res_kept", {102'd0, res0}, 136'h3FFFF);
      tick();
      p_all[0] = {102'd0, 34'h20010};
      rdy[0] = 1'b1; vld[0] = 1'b1; w[0] = 17'h00015; tick();
      chk("t3_new_cnt", {134'd0, cnt0},   136'd1);
      chk("t3_busy",    {135'd0, busy[0]}, 136'd1);

      // Test 4: final subtraction (RES >= p, then RES < p)
      rdy[0] = 1'b0; w[0] = 17'h00001; tick();
      vld[0] = 1'b0;
`ifdef FIOS_RES_FINAL_SUB_EN
      chk("t4_sub", {102'd0, res0}, 136'h00005);
`else
      chk("t4_raw", {102'd0, res0}, 136'h20015);
`endif
      rdy[0] = 1'b1; tick();
      rdy[0] = 1'b0;
      vld[0] = 1'b1; w[0] = 17'h0000F; tick();
      w[0] = 17'h00001; tick();
      vld[0] = 1'b0;
      chk("t4_nosub", {102'd0, res0}, 136'h2000F);
      chk("t4_ovf_sticky", {135'd0, ovf[0]}, 136'd1);
      rdy[0] = 1'b1; tick();

      // Test 5: s=8, reset after four limbs, then limbs 1..8
      vld[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w[1] = 17'(17'h0AA00 + i); tick();
      end
      vld[1] = 1'b0; rst_n[1] = 1'b0; tick();
      chk("t5_rst_busy",  {135'd0, busy[1]}, 136'd0);
      chk("t5_rst_cnt",   {132'd0, cnt1},    136'd0);
      chk("t5_rst_res",   res1,              136'd0);
      tick();
      rst_n[1] = 1'b1;
      exp8 = '0;
      vld[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         w[1] = 17'(i + 1);
         exp8[i*17 +: 17] = 17'(i + 1);
         tick();
      end
      vld[1] = 1'b0;
      chk("t5_valid", {135'd0, rv[1]}, 136'd1);
      chk("t5_res",   res1,            exp8);
      chk("t5_cnt",   {132'd0, cnt1},  136'd8);

      // Test 6: three back-to-back results with ready tied high
      rdy[1] = 1'b1; tick();
      vld[1] = 1'b1;
      for (int i = 0; i < 24; i++) begin
         w[1] = 17'(17'h00100 + i);
         tick();
         if (rv[1]) pulses.push_back(i);
      end
      vld[1] = 1'b0;
      chk("t6_pulses", 136'(pulses.size()), 136'd3);
      if (pulses.size() == 3) begin
         chk("t6_gap_a", 136'(pulses[1] - pulses[0]), 136'd8);
         chk("t6_gap_b", 136'(pulses[2] - pulses[1]), 136'd8);
      end
      chk("t6_ovf", {135'd0, ovf[1]}, 136'd0);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/fios_res_collector.md
Name: fios_res_collector

Overview:
- Receiving end of the FIOS multiplier result stream.
- The multiplier emits one 17-bit result limb per valid cycle, least-significant first. This block gathers s limbs into a full s*17-bit result and presents it on a valid/ready output handshake.
- With FINAL_SUB_EN, it performs the Montgomery final conditional subtraction of p, serially as limbs arrive. The output is then fully reduced into [0, p).

Parameters:
- s, 8, number of 17-bit limbs per result (same s as the multiplier).
- WORD_W, 17, limb width; fixed at 17 for DSP compatibility, parameterised only for bench convenience.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- word_valid_i  in  1  limb strobe from the multiplier controller, aligned with word_i.
- word_i  in  WORD_W  result limb (the multiplier's RES_o), LSB limb first.
- p_i  in  s*WORD_W  modulus. Must be stable from the first limb of a result until that result is accepted. Ignored without FINAL_SUB_EN.
- res_o  out  s*WORD_W  assembled result; limb k sits at bits [k*WORD_W +: WORD_W].
- res_valid_o  out  1  result available.
- res_ready_i  in  1  downstream accepts the result.
- busy_o  out  1  a partial result is being collected.
- overflow_o  out  1  sticky: a limb arrived while a completed result was still waiting.
- word_cnt_o  out  $clog2(s+1)  number of limbs collected for the current result.

Behaviour:
- Reset (reset_n_i=0 at a clock edge): state IDLE. All outputs are 0: res_o, res_valid_o, busy_o, overflow_o, word_cnt_o. Internal borrow and select flags are also cleared.
- Reset mid-collection or while FULL: the partial or pending result is discarded and no handshake occurs.
- FSM states: IDLE, COLLECT, FULL.
- IDLE, word_valid_i=1:
  - store the limb at index 0; word_cnt=1;
  - go to COLLECT, or directly to FULL if s==1.
- COLLECT:
  - busy_o=1.
  - Each word_valid_i=1 cycle stores the limb at index word_cnt, then word_cnt++.
  - Gaps with word_valid_i=0 hold all state; limbs need not be contiguous.
  - When the limb at index s-1 is stored, go to FULL.
- Latency: res_valid_o=1 in the cycle after the edge that captured the last limb. res_o is valid in that same cycle.
- FULL:
  - res_valid_o=1, busy_o=0, word_cnt_o=s.
  - res_o is held stable until the handshake.
- Handshake: res_valid_o & res_ready_i at an edge → result consumed; word_cnt=0; go to IDLE.
- Handshake and word_valid_i=1 in the same cycle: the limb is accepted as limb 0 of the next result; word_cnt=1; go to COLLECT (or FULL if s==1). There is no bubble.
- word_valid_i=1 in FULL without res_ready_i:
  - the limb is dropped and overflow_o is set;
  - overflow_o stays set until reset;
  - the pending result is unaffected.
- res_ready_i is ignored when res_valid_o=0.
- Each limb is stored as an unsigned WORD_W-bit value. No carry normalisation is applied to the raw value.

Optional Feature:
- Macro: FIOS_RES_FINAL_SUB_EN.
- Defined:
  - Per accepted limb k: diff_k = word_i - p_i[k] - borrow, computed at WORD_W+1 bits.
  - The low WORD_W bits go to a diff register at index k. Borrow takes the top bit; borrow is cleared at limb 0, i.e. limb 0 uses borrow-in 0.
  - On the last limb, the select flag is registered as sel = final borrow.
  - res_o = sel ? raw limbs : diff limbs, i.e. raw if RES < p, else RES - p.
  - Same 1-cycle latency as without the macro.
  - Input precondition: RES < 2p.
- Not defined:
  - The diff register, borrow and sel logic are absent.
  - res_o is always the raw limbs and p_i is unused.

Test Plan:
1. s=2, reset, then limbs 0x00005, 0x00003 on consecutive cycles, res_ready_i=1 → res_valid_o high one cycle after the second limb with res_o = {0x00003,0x00005}; back to IDLE the next cycle.
2. s=2, limbs 0x1FFFF, gap of 3 idle cycles, 0x00001 → busy_o=1 and word_cnt_o=1 held through the gap; res_o = {0x00001,0x1FFFF}.
3. s=2, result completed, res_ready_i=0 for 4 cycles, then word_valid_i=1 → overflow_o=1 (sticky), res_o unchanged; then a handshake with word_valid_i=1 in the same cycle → new limb 0 is captured and word_cnt_o=1.
4. s=2, FINAL_SUB_EN, p={0x00001,0x00010}, RES limbs 0x00015, 0x00001 → res_o = {0x00000,0x00005}; RES limbs 0x0000F, 0x00001 (RES<p) → res_o = {0x00001,0x0000F}.
5. s=8, reset_n_i=0 after 4 limbs, then 8 fresh limbs 1..8 → outputs are 0 during reset; the result equals limbs 1..8 only.
6. s=8, 3 back-to-back results with res_ready_i tied high → 3 res_valid_o pulses 8 cycles apart and overflow_o=0.
